sort_mem_ctrl: RTL and testbench
================================

Name: sort_mem_ctrl

Overview:
Owns the 32x8 element memory used by the bubble-sort engine and acts as the responder on the engine's address/wdata/rdata port. Loads an N-element array from a host input stream and pulses start to the sort controller. On sort done, streams the sorted array back out to the host. It sits between the host and the sort datapath/controller pair.

Parameters:
DW, 8, element width (matches engine wdata/rdata)
AW, 5, address width (matches engine address)
DEPTH, 32, number of memory words (2**AW)

Ports:
m_clk  in  1  clock; all state changes on rising edge
m_rst_n  in  1  reset, synchronous, active-low
m_n  in  6  element count; sampled on first accepted input beat
m_in_valid  in  1  host input beat valid
m_in_data  in  DW  host input element
m_in_ready  out  1  block accepts input beat
m_start  out  1  one-cycle pulse to sort controller: array loaded
m_sort_done  in  1  sort controller finished (level or pulse)
m_address  in  AW  engine access address
m_wdata  in  DW  engine write data
m_we  in  1  engine write enable
m_rdata  out  DW  engine read data
m_out_valid  out  1  host output beat valid
m_out_data  out  DW  host output element
m_out_last  out  1  marks final output beat
m_busy  out  1  high in START and SORT

Behaviour:
- States: LOAD, START, SORT, UNLOAD. Reset -> LOAD, cnt=0, n_q=DEPTH. Outputs: m_in_ready=1, m_start=0, m_out_valid=0, m_out_last=0, m_busy=0. Memory contents are not reset.
- Count clamp: n_q = DEPTH when m_n==0 or m_n>DEPTH; otherwise n_q = m_n. Latched when cnt==0 and an input handshake occurs in LOAD.
- LOAD: m_in_ready=1. A handshake (valid&ready) writes mem[cnt]=m_in_data and increments cnt. A handshake with cnt==n_q-1 (using the clamped value, including the same-cycle latch when cnt==0) -> START, cnt=0.
- START: m_in_ready=0, m_start=1 for exactly this cycle, m_busy=1. Next state SORT unconditionally.
- SORT: m_busy=1. When m_we=1, mem[m_address] is written at the clock edge. m_sort_done=1 -> UNLOAD, cnt=0. If m_we and m_sort_done are high in the same cycle, the write completes and then the transition occurs.
- m_rdata = mem[m_address], asynchronous and combinational, in all states, so the engine can register it into its temp registers the same cycle. Read-during-write on the same address returns the old value; the new value is visible the next cycle.
- m_we is ignored outside SORT. m_sort_done is ignored outside SORT. m_in_valid is ignored outside LOAD.
- UNLOAD:
  - m_out_valid=1, m_out_data=mem[cnt], m_out_last=(cnt==n_q-1).
  - m_out_data and m_out_last hold stable while m_out_valid & !m_out_ready.
  - A handshake increments cnt. A handshake with m_out_last -> LOAD, cnt=0; m_out_valid drops the next cycle.
- n_q==1: one load beat -> START -> SORT (waits for done) -> a single output beat with m_out_last=1.
- Address width: cnt is AW+1 bits. Memory index uses cnt[AW-1:0]. Comparisons use the full width, so n_q=32 terminates at cnt==31 without wrap.
- Reset mid-operation, in any state: return to LOAD, cnt=0, all handshake outputs take reset values, and any partial array or pending output is discarded.
- No combinational path from m_out_ready to m_out_valid, or from m_in_valid to m_in_ready.

Test Plan:
- Basic load: m_n=4, beats 0x30,0x10,0x40,0x20 with m_in_valid held high -> m_in_ready=1 for 4 cycles. m_start pulses exactly 1 cycle after the 4th beat, and m_busy=1 from that cycle.
- Engine port: in SORT, drive m_address=1 and check m_rdata=0x10 in the same cycle. Write m_we=1, addr=1, data=0x99 -> next cycle m_rdata=0x99. A write attempted in LOAD or UNLOAD does not modify memory.
- Unload with backpressure: load 0x30,0x10,0x40,0x20; engine writes the sorted order; pulse m_sort_done. Toggle m_out_ready 1,0,0,1,1,1 -> outputs 0x10,0x20,0x30,0x40. Data is stable across stall cycles, m_out_last is high only on 0x40, and the block returns to LOAD with m_in_ready=1.
- Boundaries:
  - m_n=0: 32 beats accepted; unload gives 32 beats, last on index 31.
  - m_n=40: clamped to 32.
  - m_n=1: 1 beat in, start, done, 1 beat out with last=1.
- Simultaneous events: m_we (addr 3, data 0x55) and m_sort_done in the same cycle -> the 4th output beat = 0x55.
- Reset mid-SORT: assert m_rst_n=0 for 1 cycle -> next cycle LOAD, m_busy=0, m_out_valid=0, m_in_ready=1. A new load of m_n=2 operates normally.

Source files
------------

// File: rtl/sort_mem_ctrl.sv
// Element memory and host load/unload sequencer for the bubble-sort engine.
// Latency: start pulses the cycle after the final load beat; output data is read straight from memory.
// Backpressure: m_in_ready is high only in LOAD; while m_out_ready is low, the current output beat holds.
module sort_mem_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          m_clk,
    input  logic          m_rst_n,
    input  logic [AW:0]   m_n,
    input  logic          m_in_valid,
    input  logic [DW-1:0] m_in_data,
    output logic          m_in_ready,
    output logic          m_start,
    input  logic          m_sort_done,
    input  logic [AW-1:0] m_address,
    input  logic [DW-1:0] m_wdata,
    input  logic          m_we,
    output logic [DW-1:0] m_rdata,
    output logic          m_out_valid,
    output logic [DW-1:0] m_out_data,
    output logic          m_out_last,
    input  logic          m_out_ready,
    output logic          m_busy
);

    typedef enum logic [1:0] {S_LOAD, S_START, S_SORT, S_UNLOAD} state_t;

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_n_q;
    logic          r_in_ready;
    logic          r_start;
    logic          r_busy;
    logic          r_out_valid;
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW:0]   w_n_clamp;
    logic [AW:0]   w_n_eff;
    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_out_last;

    // The count is latched on the first beat, so that beat must already see the clamped value.
    assign w_n_clamp  = (m_n == '0 || m_n > C_DEPTH) ? C_DEPTH : m_n;
    assign w_n_eff    = (r_cnt == '0) ? w_n_clamp : r_n_q;
    assign w_in_hs    = (r_state == S_LOAD) && m_in_valid;
    assign w_out_hs   = r_out_valid && m_out_ready;
    assign w_out_last = (r_cnt == r_n_q - 1'b1);

    assign m_in_ready  = r_in_ready;
    assign m_start     = r_start;
    assign m_busy      = r_busy;
    assign m_out_valid = r_out_valid;
    assign m_out_data  = r_mem[r_cnt[AW-1:0]];
    assign m_out_last  = r_out_valid && w_out_last;
    assign m_rdata     = r_mem[m_address];

    always_ff @(posedge m_clk) begin
        if (m_rst_n && w_in_hs) begin
            r_mem[r_cnt[AW-1:0]] <= m_in_data;
        end else if (m_rst_n && r_state == S_SORT && m_we) begin
            r_mem[m_address] <= m_wdata;
        end
    end

    always_ff @(posedge m_clk) begin
        if (!m_rst_n) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_n_q       <= C_DEPTH;
            r_in_ready  <= 1'b1;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_hs) begin
                        if (r_cnt == '0) begin
                            r_n_q <= w_n_clamp;
                        end
                        if (r_cnt == w_n_eff - 1'b1) begin
                            r_state    <= S_START;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_start    <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_SORT;
                    r_start <= 1'b0;
                end
                S_SORT: begin
                    if (m_sort_done) begin
                        r_state     <= S_UNLOAD;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_out_hs) begin
                        if (w_out_last) begin
                            r_state     <= S_LOAD;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_mem_ctrl.sv
// Directed bench for sort_mem_ctrl: memory model plus output scoreboard queue.
module tb_sort_mem_ctrl;
    localparam int DW = 8, AW = 5, DEPTH = 32;

    logic          m_clk = 1'b0;
    logic          m_rst_n;
    logic [AW:0]   m_n;
    logic          m_in_valid;
    logic [DW-1:0] m_in_data;
    logic          m_in_ready;
    logic          m_start;
    logic          m_sort_done;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [DW-1:0] m_rdata;
    logic          m_out_valid;
    logic [DW-1:0] m_out_data;
    logic          m_out_last;
    logic          m_out_ready;
    logic          m_busy;

    always #5 m_clk = ~m_clk;

    sort_mem_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .m_clk(m_clk), .m_rst_n(m_rst_n), .m_n(m_n),
        .m_in_valid(m_in_valid), .m_in_data(m_in_data), .m_in_ready(m_in_ready),
        .m_start(m_start), .m_sort_done(m_sort_done),
        .m_address(m_address), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
        .m_out_valid(m_out_valid), .m_out_data(m_out_data), .m_out_last(m_out_last),
        .m_out_ready(m_out_ready), .m_busy(m_busy)
    );

    int checks = 0;
    int errors = 0;
    int cur_n  = 0;
    logic [7:0] mdl [DEPTH];
    logic [7:0] ld  [DEPTH];
    logic [8:0] sb  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] n);
        int cnt;
        cnt   = (n == 0 || n > DEPTH) ? DEPTH : int'(n);
        cur_n = cnt;
        for (int i = 0; i < cnt; i++) begin
            @(negedge m_clk);
            m_n = n; m_in_valid = 1'b1; m_in_data = ld[i];
            #1;
            chk("load_in_ready", m_in_ready, 1);
            chk("load_start_early", m_start, 0);
            mdl[i] = ld[i];
        end
        @(negedge m_clk);
        m_in_valid = 1'b0;
        #1;
        chk("start_pulse", m_start, 1);
        chk("start_busy", m_busy, 1);
        chk("start_in_ready", m_in_ready, 0);
        @(negedge m_clk);
        #1;
        chk("sort_start_low", m_start, 0);
        chk("sort_busy", m_busy, 1);
    endtask

    task automatic eng_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge m_clk);
        m_we = 1'b1; m_address = a; m_wdata = d;
        #1;
        chk("rdata_old", m_rdata, mdl[a]);
        mdl[a] = d;
        @(negedge m_clk);
        m_we = 1'b0;
        #1;
        chk("rdata_new", m_rdata, mdl[a]);
    endtask

    task automatic finish_sort(input bit w, input logic [4:0] a, input logic [7:0] d);
        @(negedge m_clk);
        m_sort_done = 1'b1; m_we = w; m_address = a; m_wdata = d;
        if (w) mdl[a] = d;
        for (int i = 0; i < cur_n; i++) sb.push_back({(i == cur_n - 1), mdl[i]});
        @(negedge m_clk);
        m_sort_done = 1'b0; m_we = 1'b0;
        #1;
        chk("unload_valid", m_out_valid, 1);
        chk("unload_busy", m_busy, 0);
        chk("unload_in_ready", m_in_ready, 0);
    endtask

    task automatic unload(input logic [15:0] pat, input int plen);
        int cyc;
        logic [8:0] e;
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge m_clk);
            m_out_ready = (cyc < plen) ? pat[cyc] : 1'b1;
            #1;
            e = sb[0];
            chk("out_valid", m_out_valid, 1);
            chk("out_data", m_out_data, e[7:0]);
            chk("out_last", m_out_last, e[8]);
            if (m_out_ready) void'(sb.pop_front());
            cyc++;
        end
        if (sb.size() != 0) begin
            chk("unload_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge m_clk);
        m_out_ready = 1'b0;
        #1;
        chk("done_out_valid", m_out_valid, 0);
        chk("done_in_ready", m_in_ready, 1);
        chk("done_busy", m_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        m_rst_n = 1'b0; m_n = '0; m_in_valid = 1'b0; m_in_data = '0;
        m_sort_done = 1'b0; m_address = '0; m_wdata = '0; m_we = 1'b0; m_out_ready = 1'b0;
        repeat (2) @(negedge m_clk);
        #1;
        chk("rst_in_ready", m_in_ready, 1);
        chk("rst_start", m_start, 0);
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_last", m_out_last, 0);
        chk("rst_busy", m_busy, 0);
        m_rst_n = 1'b1;

        // Basic load, engine access, backpressured unload
        ld[0] = 8'h30; ld[1] = 8'h10; ld[2] = 8'h40; ld[3] = 8'h20;
        load(6'd4);
        eng_write(5'd1, 8'h99);
        eng_write(5'd0, 8'h10);
        eng_write(5'd1, 8'h20);
        eng_write(5'd2, 8'h30);
        eng_write(5'd3, 8'h40);
        finish_sort(1'b0, 5'd0, 8'h00);
        unload(16'h0039, 6);

        // Write in LOAD is ignored
        @(negedge m_clk);
        m_we = 1'b1; m_address = 5'd0; m_wdata = 8'hEE;
        @(negedge m_clk);
        m_we = 1'b0;
        #1;
        chk("load_we_ignored", m_rdata, mdl[0]);

        // n=1, waits in SORT, write in UNLOAD ignored
        ld[0] = 8'h77;
        load(6'd1);
        repeat (3) begin
            @(negedge m_clk);
            #1;
            chk("sort_wait_busy", m_busy, 1);
            chk("sort_wait_no_out", m_out_valid, 0);
        end
        finish_sort(1'b0, 5'd0, 8'h00);
        @(negedge m_clk);
        m_out_ready = 1'b0; m_we = 1'b1; m_address = 5'd0; m_wdata = 8'hEE;
        @(negedge m_clk);
        m_we = 1'b0;
        #1;
        chk("unload_we_ignored", m_rdata, 8'h77);
        unload(16'h0000, 0);

        // Write and done in the same cycle
        ld[0] = 8'h01; ld[1] = 8'h02; ld[2] = 8'h03; ld[3] = 8'h04;
        load(6'd4);
        finish_sort(1'b1, 5'd3, 8'h55);
        unload(16'h0000, 0);

        // n=0 and n=40 both clamp to 32
        for (int i = 0; i < DEPTH; i++) ld[i] = 8'(i * 3 + 1);
        load(6'd0);
        finish_sort(1'b0, 5'd0, 8'h00);
        unload(16'h0000, 0);
        for (int i = 0; i < DEPTH; i++) ld[i] = 8'(255 - i * 5);
        load(6'd40);
        finish_sort(1'b0, 5'd0, 8'h00);
        unload(16'h00A5, 8);

        // Reset mid-SORT, then a normal n=2 run
        ld[0] = 8'hC1; ld[1] = 8'hC2; ld[2] = 8'hC3; ld[3] = 8'hC4;
        load(6'd4);
        @(negedge m_clk);
        m_rst_n = 1'b0;
        @(negedge m_clk);
        m_rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", m_in_ready, 1);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_out_valid", m_out_valid, 0);
        chk("midrst_start", m_start, 0);
        ld[0] = 8'hA1; ld[1] = 8'hB2;
        load(6'd2);
        finish_sort(1'b0, 5'd0, 8'h00);
        unload(16'h0002, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
